// File: rtl/traffic_phase_sequencer.sv
// Traffic-light phase sequencer: programmable patterns and sensor-selected duration tables,
// with an internal 1 Hz prescaler plus flashing-yellow and off modes.
module traffic_phase_sequencer #(
    parameter int CLK_HZ   = 10000,
    parameter int N_PHASES = 11,
    parameter int N_LIGHTS = 9,
    parameter int N_SENS   = 3,
    parameter int TW       = 8,
    localparam int PW = (N_PHASES > 1) ? $clog2(N_PHASES) : 1,
    localparam int LW = 2 * N_LIGHTS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              flash,
    input  logic [N_SENS-1:0] sensors,
    input  logic              cfg_we,
    input  logic              cfg_sel,
    input  logic [7:0]        cfg_addr,
    input  logic [31:0]       cfg_data,
    output logic [LW-1:0]     lights,
    output logic [PW-1:0]     phase,
    output logic [TW-1:0]     secs_left,
    output logic              phase_start
);

    localparam int N_TABLES  = N_SENS + 1;
    localparam int DUR_DEPTH = N_TABLES * N_PHASES;
    localparam int DAW       = (DUR_DEPTH > 1) ? $clog2(DUR_DEPTH) : 1;
    localparam int TSW       = $clog2(N_TABLES);
    localparam int CW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    localparam logic [LW-1:0] ALL_OFF    = '1;
    localparam logic [LW-1:0] ALL_YELLOW = {N_LIGHTS{2'b01}};
    localparam logic [LW-1:0] ALL_RED    = '0;
    localparam logic [CW-1:0] PRESC_MAX  = CW'(CLK_HZ - 1);
    localparam logic [PW-1:0] LAST_PHASE = PW'(N_PHASES - 1);

    typedef enum logic [1:0] {
        S_OFF,
        S_LOAD,
        S_COUNT,
        S_FLASH
    } state_e;

    state_e          state_q;
    logic [LW-1:0]   lights_q;
    logic [PW-1:0]   phase_q;
    logic [TW-1:0]   secs_q;
    logic            phase_start_q;
    logic [CW-1:0]   presc_q;
    logic            blink_q;

    logic [TW-1:0]   dur_q [DUR_DEPTH];
    logic [LW-1:0]   pat_q [N_PHASES];

    logic [TSW-1:0]  tbl_sel;
    logic [DAW-1:0]  rd_idx;
    logic [TW-1:0]   dur_rd;
    logic [PW-1:0]   phase_nxt;
    logic            tick;

    // Only the configured width of each word is stored; the xor keeps the full bus referenced.
    wire unused_cfg_bits = ^cfg_data;

    // NOTE: these tables are small flop arrays, so reset can clear them; a RAM macro could not be reset this way.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DUR_DEPTH; i++) dur_q[i] <= '0;
            for (int i = 0; i < N_PHASES; i++)  pat_q[i] <= ALL_RED;
        end else if (cfg_we) begin
            if (!cfg_sel) begin
                if (int'(cfg_addr) < DUR_DEPTH) dur_q[cfg_addr[DAW-1:0]] <= cfg_data[TW-1:0];
            end else if (int'(cfg_addr) < N_PHASES) begin
                pat_q[cfg_addr[PW-1:0]] <= cfg_data[LW-1:0];
            end
        end
    end

    // Exactly one active sensor picks its own table; none or several fall back to table 0.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        int n_set;
        n_set   = 0;
        tbl_sel = '0;
        for (int i = 0; i < N_SENS; i++) begin
            if (sensors[i]) begin
                n_set   = n_set + 1;
                tbl_sel = TSW'(i + 1);
            end
        end
        if (n_set != 1) tbl_sel = '0;
    end

    assign rd_idx    = DAW'(int'(tbl_sel) * N_PHASES + int'(phase_q));
    assign dur_rd    = dur_q[rd_idx];
    assign phase_nxt = (phase_q == LAST_PHASE) ? '0 : phase_q + 1'b1;
    assign tick      = (presc_q == PRESC_MAX);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_OFF;
            lights_q      <= ALL_OFF;
            phase_q       <= '0;
            secs_q        <= '0;
            phase_start_q <= 1'b0;
            presc_q       <= '0;
            blink_q       <= 1'b0;
        end else begin
            phase_start_q <= 1'b0;
            if (!enable) begin
                state_q  <= S_OFF;
                lights_q <= ALL_OFF;
                secs_q   <= '0;
            end else if (flash) begin
                if (state_q != S_FLASH) begin
                    state_q  <= S_FLASH;
                    lights_q <= ALL_YELLOW;
                    secs_q   <= '0;
                    presc_q  <= '0;
                    blink_q  <= 1'b0;
                end else begin
                    presc_q <= tick ? '0 : presc_q + 1'b1;
                    // blink_q is set while the heads are dark
                    if (tick) begin
                        lights_q <= blink_q ? ALL_YELLOW : ALL_OFF;
                        blink_q  <= ~blink_q;
                    end
                end
            end else begin
                case (state_q)
                    S_OFF, S_FLASH: begin
                        phase_q <= '0;
                        state_q <= S_LOAD;
                    end
                    S_LOAD: begin
                        if (dur_rd == '0) begin
                            phase_q <= phase_nxt;
                        end else begin
                            lights_q      <= pat_q[phase_q];
                            secs_q        <= dur_rd;
                            phase_start_q <= 1'b1;
                            presc_q       <= '0;
                            state_q       <= S_COUNT;
                        end
                    end
                    S_COUNT: begin
                        presc_q <= tick ? '0 : presc_q + 1'b1;
                        if (tick) begin
                            secs_q <= secs_q - 1'b1;
                            if (secs_q == TW'(1)) begin
                                phase_q <= phase_nxt;
                                state_q <= S_LOAD;
                            end
                        end
                    end
                    default: state_q <= S_OFF;
                endcase
            end
        end
    end

    assign lights      = lights_q;
    assign phase       = phase_q;
    assign secs_left   = secs_q;
    assign phase_start = phase_start_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench for traffic_phase_sequencer: sequencing, table select, skip, flash, off and reset.
module tb_traffic_phase_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        flash;
    logic [2:0]  sensors;
    logic        cfg_we;
    logic        cfg_sel;
    logic [7:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic [5:0]  lights;
    logic [1:0]  phase;
    logic [7:0]  secs_left;
    logic        phase_start;

    int total = 0;
    int bad   = 0;

    traffic_phase_sequencer #(
        .CLK_HZ(10), .N_PHASES(4), .N_LIGHTS(3), .N_SENS(3), .TW(8)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .flash(flash), .sensors(sensors),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .lights(lights), .phase(phase), .secs_left(secs_left), .phase_start(phase_start)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_pulse(input int budget, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (phase_start !== 1'b1 && cycles < budget);
        if (phase_start !== 1'b1) cycles = -1;
    endtask

    task automatic cfg_write(input logic sel, input logic [7:0] addr, input logic [31:0] data);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_addr = addr;
        cfg_data = data;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic test_reset();
        logic [1:0] ep;
        reset = 1'b1; enable = 1'b1; flash = 1'b0; sensors = '0;
        cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({lights, phase, secs_left, phase_start} !== {6'h3F, 2'd0, 8'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: lights=%h phase=%0d secs=%0d start=%b, want 3f/0/0/0",
                     lights, phase, secs_left, phase_start);
        end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ep = 2'(i);
            total++;
            if (phase !== ep || lights !== 6'h3F || phase_start !== 1'b0) begin
                bad++;
                $display("FAIL zero_cycle[%0d]: phase=%0d lights=%h start=%b, want %0d/3f/0",
                         i, phase, lights, phase_start, ep);
            end
        end
    endtask

    task automatic test_sequence();
        logic [5:0] pats [4] = '{6'h00, 6'h2A, 6'h15, 6'h0A};
        logic [7:0] durs [4] = '{8'd2, 8'd1, 8'd3, 8'd1};
        int         lens [4] = '{11, 0, 11, 31};   // length of the phase ending when phase k loads
        int         cyc;
        enable = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) cfg_write(1'b1, 8'(k), 32'(pats[k]));
        for (int k = 0; k < 4; k++) cfg_write(1'b0, 8'(k), 32'(durs[k]));
        enable = 1'b1;
        @(negedge clk);
        total++;
        if (phase !== 2'd0 || phase_start !== 1'b0 || lights !== 6'h3F) begin
            bad++;
            $display("FAIL seq_load: phase=%0d start=%b lights=%h, want 0/0/3f", phase, phase_start, lights);
        end
        @(negedge clk);
        total++;
        if ({phase_start, lights, secs_left, phase} !== {1'b1, 6'h00, 8'd2, 2'd0}) begin
            bad++;
            $display("FAIL seq_first: start=%b lights=%h secs=%0d phase=%0d, want 1/00/2/0",
                     phase_start, lights, secs_left, phase);
        end
        @(negedge clk);
        total++;
        if (phase_start !== 1'b0 || secs_left !== 8'd2) begin
            bad++;
            $display("FAIL seq_pulse_width: start=%b secs=%0d, want 0/2", phase_start, secs_left);
        end
        repeat (19) @(negedge clk);
        total++;
        if ({phase, lights, phase_start} !== {2'd1, 6'h00, 1'b0}) begin
            bad++;
            $display("FAIL seq_phase_lead: phase=%0d lights=%h start=%b, want 1/00/0", phase, lights, phase_start);
        end
        @(negedge clk);
        total++;
        if ({phase_start, lights, secs_left, phase} !== {1'b1, 6'h2A, 8'd1, 2'd1}) begin
            bad++;
            $display("FAIL seq_phase1: start=%b lights=%h secs=%0d phase=%0d, want 1/2a/1/1",
                     phase_start, lights, secs_left, phase);
        end
        for (int n = 0; n < 3; n++) begin
            int k;
            k = (n + 2) % 4;
            wait_pulse(100, cyc);
            total++;
            if (cyc != lens[k] || lights !== pats[k] || phase !== 2'(k) || secs_left !== durs[k]) begin
                bad++;
                $display("FAIL seq_phase%0d: cycles=%0d lights=%h phase=%0d secs=%0d, want %0d/%h/%0d/%0d",
                         k, cyc, lights, phase, secs_left, lens[k], pats[k], k, durs[k]);
            end
        end
        repeat (9) @(negedge clk);
        total++;
        if (secs_left !== 8'd2) begin
            bad++;
            $display("FAIL seq_secs_hold: secs=%0d, want 2", secs_left);
        end
        @(negedge clk);
        total++;
        if (secs_left !== 8'd1) begin
            bad++;
            $display("FAIL seq_secs_tick: secs=%0d, want 1", secs_left);
        end
    endtask

    task automatic test_table_select();
        int cyc;
        cfg_write(1'b0, 8'd10, 32'd5);
        wait_pulse(100, cyc);
        total++;
        if (phase !== 2'd1) begin
            bad++;
            $display("FAIL tbl_reach_p1: phase=%0d cycles=%0d, want 1", phase, cyc);
        end
        sensors = 3'b010;
        wait_pulse(100, cyc);
        total++;
        if (cyc != 11 || phase !== 2'd2 || secs_left !== 8'd5) begin
            bad++;
            $display("FAIL tbl_sel2_load: cycles=%0d phase=%0d secs=%0d, want 11/2/5", cyc, phase, secs_left);
        end
        sensors = 3'b000;
        wait_pulse(100, cyc);
        total++;
        if (cyc != 51 || phase !== 2'd3 || lights !== 6'h0A) begin
            bad++;
            $display("FAIL tbl_sel2_len: cycles=%0d phase=%0d lights=%h, want 51/3/0a", cyc, phase, lights);
        end
        wait_pulse(100, cyc);
        wait_pulse(100, cyc);
        total++;
        if (phase !== 2'd1 || cyc != 21) begin
            bad++;
            $display("FAIL tbl_reach_p1b: phase=%0d cycles=%0d, want 1/21", phase, cyc);
        end
        sensors = 3'b011;
        wait_pulse(100, cyc);
        total++;
        if (phase !== 2'd2 || secs_left !== 8'd3) begin
            bad++;
            $display("FAIL tbl_multi_bits: phase=%0d secs=%0d, want 2/3", phase, secs_left);
        end
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 5)  sensors = 3'b010;
            if (cyc == 15) sensors = 3'b100;
            if (cyc == 25) sensors = 3'b000;
        end while (phase_start !== 1'b1 && cyc < 100);
        total++;
        if (cyc != 31 || phase !== 2'd3) begin
            bad++;
            $display("FAIL tbl_midphase_toggle: cycles=%0d phase=%0d, want 31/3", cyc, phase);
        end
    endtask

    task automatic test_skip();
        int cyc;
        cfg_write(1'b0, 8'd1, 32'd0);
        wait_pulse(100, cyc);
        total++;
        if (phase !== 2'd0) begin
            bad++;
            $display("FAIL skip_reach_p0: phase=%0d cycles=%0d, want 0", phase, cyc);
        end
        repeat (19) @(negedge clk);
        total++;
        if (phase !== 2'd0 || phase_start !== 1'b0) begin
            bad++;
            $display("FAIL skip_p0_end: phase=%0d start=%b, want 0/0", phase, phase_start);
        end
        @(negedge clk);
        total++;
        if (phase !== 2'd1 || phase_start !== 1'b0) begin
            bad++;
            $display("FAIL skip_p1_visible: phase=%0d start=%b, want 1/0", phase, phase_start);
        end
        @(negedge clk);
        total++;
        if ({phase, phase_start, lights} !== {2'd2, 1'b0, 6'h00}) begin
            bad++;
            $display("FAIL skip_p1_gone: phase=%0d start=%b lights=%h, want 2/0/00", phase, phase_start, lights);
        end
        @(negedge clk);
        total++;
        if ({phase_start, phase, lights, secs_left} !== {1'b1, 2'd2, 6'h15, 8'd3}) begin
            bad++;
            $display("FAIL skip_p2_load: start=%b phase=%0d lights=%h secs=%0d, want 1/2/15/3",
                     phase_start, phase, lights, secs_left);
        end
    endtask

    task automatic test_flash();
        repeat (5) @(negedge clk);
        flash = 1'b1;
        @(negedge clk);
        total++;
        if ({lights, secs_left, phase_start} !== {6'h15, 8'd0, 1'b0}) begin
            bad++;
            $display("FAIL flash_entry: lights=%h secs=%0d start=%b, want 15/0/0", lights, secs_left, phase_start);
        end
        repeat (9) @(negedge clk);
        total++;
        if (lights !== 6'h15) begin
            bad++;
            $display("FAIL flash_hold_on: lights=%h, want 15", lights);
        end
        @(negedge clk);
        total++;
        if (lights !== 6'h3F) begin
            bad++;
            $display("FAIL flash_off: lights=%h, want 3f", lights);
        end
        repeat (9) @(negedge clk);
        total++;
        if (lights !== 6'h3F) begin
            bad++;
            $display("FAIL flash_hold_off: lights=%h, want 3f", lights);
        end
        @(negedge clk);
        total++;
        if (lights !== 6'h15) begin
            bad++;
            $display("FAIL flash_on_again: lights=%h, want 15", lights);
        end
        flash = 1'b0;
        @(negedge clk);
        total++;
        if (phase !== 2'd0 || phase_start !== 1'b0) begin
            bad++;
            $display("FAIL flash_exit: phase=%0d start=%b, want 0/0", phase, phase_start);
        end
        @(negedge clk);
        total++;
        if ({phase_start, phase, lights, secs_left} !== {1'b1, 2'd0, 6'h00, 8'd2}) begin
            bad++;
            $display("FAIL flash_restart: start=%b phase=%0d lights=%h secs=%0d, want 1/0/00/2",
                     phase_start, phase, lights, secs_left);
        end
    endtask

    task automatic test_off_and_reset();
        int         cyc;
        logic [1:0] ep;
        repeat (3) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        total++;
        if ({lights, secs_left, phase_start} !== {6'h3F, 8'd0, 1'b0}) begin
            bad++;
            $display("FAIL off_entry: lights=%h secs=%0d start=%b, want 3f/0/0", lights, secs_left, phase_start);
        end
        repeat (5) @(negedge clk);
        total++;
        if ({lights, secs_left, phase_start} !== {6'h3F, 8'd0, 1'b0}) begin
            bad++;
            $display("FAIL off_hold: lights=%h secs=%0d start=%b, want 3f/0/0", lights, secs_left, phase_start);
        end
        enable = 1'b1;
        @(negedge clk);
        total++;
        if (phase !== 2'd0 || phase_start !== 1'b0) begin
            bad++;
            $display("FAIL off_exit: phase=%0d start=%b, want 0/0", phase, phase_start);
        end
        @(negedge clk);
        total++;
        if ({phase_start, phase, lights, secs_left} !== {1'b1, 2'd0, 6'h00, 8'd2}) begin
            bad++;
            $display("FAIL off_restart: start=%b phase=%0d lights=%h secs=%0d, want 1/0/00/2",
                     phase_start, phase, lights, secs_left);
        end
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({lights, phase, secs_left, phase_start} !== {6'h3F, 2'd0, 8'd0, 1'b0}) begin
            bad++;
            $display("FAIL midrun_reset: lights=%h phase=%0d secs=%0d start=%b, want 3f/0/0/0",
                     lights, phase, secs_left, phase_start);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ep = 2'(i);
            total++;
            if (phase !== ep || lights !== 6'h3F || phase_start !== 1'b0) begin
                bad++;
                $display("FAIL cleared_dur[%0d]: phase=%0d lights=%h start=%b, want %0d/3f/0",
                         i, phase, lights, phase_start, ep);
            end
        end
        cfg_write(1'b0, 8'd16, 32'd5);
        cfg_write(1'b0, 8'd3, 32'd1);
        wait_pulse(20, cyc);
        total++;
        if (cyc < 1 || cyc > 5 || phase !== 2'd3 || lights !== 6'h00 || secs_left !== 8'd1) begin
            bad++;
            $display("FAIL cleared_pat_oob: cycles=%0d phase=%0d lights=%h secs=%0d, want 1..5/3/00/1",
                     cyc, phase, lights, secs_left);
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_table_select();
        test_skip();
        test_flash();
        test_off_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
